// File: rtl/keypad_key_buffer.sv
// keypad_key_buffer: debounces the scan FSM's DATA/PRESS stream into one key code
// per physical press and queues the codes in a small FIFO popped by the MCU.
// Optional feature macro: KEYBUF_AUTOREPEAT_EN (re-push the held code every
// REPEAT_CYC cycles while the key stays held). Undefined by default.
//
// state | meaning
// IDLE  | no key; waiting for PRESS
// QUAL  | press seen; counting consecutive stable samples of cand
// HELD  | press accepted and pushed; waiting for release
// RELQ  | release seen; counting consecutive released samples
module keypad_key_buffer #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int DEPTH        = 4,
  parameter int REPEAT_CYC   = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [3:0]               DATA,
  input  logic                     PRESS,
  input  logic                     RD_EN,
  input  logic                     CLR_OVR,
  output logic [3:0]               DOUT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERRUN,
  output logic                     INT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, QUAL, HELD, RELQ} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_deb;
  logic          push;

  // Debounce state, candidate code and stability counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce next-state; push fires on the sample that completes qualification
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push_deb = 1'b0;
    case (state_q)
      IDLE: begin
        if (PRESS) begin
          cand_d  = DATA;
          cnt_d   = CW'(1);
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (!PRESS) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (DATA != cand_q) begin
          cand_d = DATA;
          cnt_d  = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            push_deb = 1'b1;
            state_d  = HELD;
          end
        end
      end
      HELD: begin
        if (!PRESS) begin
          cnt_d   = CW'(1);
          state_d = RELQ;
        end
      end
      RELQ: begin
        if (PRESS) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEYBUF_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_q;
  logic          rep_fire;

  assign rep_fire = (state_q == HELD) && PRESS && (rep_q == REP_LAST);

  // Repeat timer runs only across continuous HELD; any exit restarts the period
  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_q <= '0;
    end else if ((state_q == HELD) && PRESS) begin
      rep_q <= rep_fire ? '0 : rep_q + RW'(1);
    end else begin
      rep_q <= '0;
    end
  end

  assign push = push_deb | rep_fire;
`else
  if (REPEAT_CYC < 1) begin : g_bad_repeat_cyc
    $error("REPEAT_CYC must be >= 1");
  end

  assign push = push_deb;
`endif

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_f, count_nx;
  logic          empty_q, full_q, ovr_q;
  logic          pop, wr_ok, ovr_set;

  assign pop     = RD_EN & ~empty_q;
  assign wr_ok   = push & (~full_q | pop);
  assign ovr_set = push & full_q & ~pop;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nx = cnt_f;
    if (wr_ok && !pop) begin
      count_nx = cnt_f + (AW + 1)'(1);
    end else if (!wr_ok && pop) begin
      count_nx = cnt_f - (AW + 1)'(1);
    end
  end

  // FIFO storage; contents need no reset since DOUT is masked while empty
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= cand_q;
    end
  end

  // Pointers, occupancy, status flags and sticky overrun
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_f   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      cnt_f   <= count_nx;
      empty_q <= (count_nx == '0);
      full_q  <= (count_nx == DEPTH_V);
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (CLR_OVR) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign DOUT    = empty_q ? 4'd0 : mem[rd_ptr];
  assign EMPTY   = empty_q;
  assign FULL    = full_q;
  assign COUNT   = cnt_f;
  assign OVERRUN = ovr_q;
  assign INT     = ~empty_q;

endmodule

// File: tb/tb_keypad_key_buffer.sv
// Directed bench for keypad_key_buffer with DEBOUNCE_CYC=4, DEPTH=4, REPEAT_CYC=20.
module tb_keypad_key_buffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] DATA = 4'd0;
  logic       PRESS = 1'b0;
  logic       RD_EN = 1'b0;
  logic       CLR_OVR = 1'b0;
  logic [3:0] DOUT;
  logic       EMPTY, FULL, OVERRUN, INT;
  logic [2:0] COUNT;

  int tests = 0;
  int failed = 0;

  keypad_key_buffer #(
    .DEBOUNCE_CYC(4),
    .DEPTH(4),
    .REPEAT_CYC(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .DATA(DATA),
    .PRESS(PRESS),
    .RD_EN(RD_EN),
    .CLR_OVR(CLR_OVR),
    .DOUT(DOUT),
    .EMPTY(EMPTY),
    .FULL(FULL),
    .COUNT(COUNT),
    .OVERRUN(OVERRUN),
    .INT(INT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] data;
    logic       press;
    logic       rd;
    logic       clr;
    logic [3:0] e_dout;
    logic [2:0] e_count;
    logic       e_ovr;
    int         sid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input int sid, input logic rst, input logic [3:0] data,
                     input logic press, input logic rd, input logic clr,
                     input logic [3:0] e_dout, input logic [2:0] e_count, input logic e_ovr);
    vec_t t;
    t.rst = rst; t.data = data; t.press = press; t.rd = rd; t.clr = clr;
    t.e_dout = e_dout; t.e_count = e_count; t.e_ovr = e_ovr; t.sid = sid;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  // Empty/full/int follow from the expected occupancy
  task automatic check(input int sid, input int step, input logic [3:0] e_dout,
                       input logic [2:0] e_count, input logic e_ovr);
    logic [10:0] act, exp;
    act = {DOUT, EMPTY, FULL, COUNT, OVERRUN, INT};
    exp = {e_dout, e_count == 3'd0, e_count == 3'd4, e_count, e_ovr, e_count != 3'd0};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL s%0d step %0d dout/empty/full/count/ovr/int got %0d/%b/%b/%0d/%b/%b need %0d/%b/%b/%0d/%b/%b",
               sid, step, DOUT, EMPTY, FULL, COUNT, OVERRUN, INT,
               e_dout, exp[6], exp[5], e_count, e_ovr, exp[0]);
    end
  endtask

  task automatic cycle(input logic rst, input logic [3:0] data, input logic press,
                       input logic rd, input logic clr);
    RST = rst; DATA = data; PRESS = press; RD_EN = rd; CLR_OVR = clr;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c_b, c_a, d_b, e_cnt;
    logic o_b, o_a;
    logic [3:0] codes [6];
    codes[0] = 4'd1; codes[1] = 4'd2; codes[2] = 4'd3;
    codes[3] = 4'd6; codes[4] = 4'd8; codes[5] = 4'd9;

    // s0: reset state
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // s1: single press of 5, lands on 4th edge; pop; pop while empty ignored
    add(3, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    add(7, 1, 0, 5, 1, 0, 0, 5, 1, 0);
    add(10, 1, 0, 5, 0, 0, 0, 5, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    // s2: PRESS 1,1,0,1,1,1,1 with DATA=7
    add(2, 2, 0, 7, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 7, 0, 0, 0, 0, 0, 0);
    add(3, 2, 0, 7, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 7, 1, 0, 0, 7, 1, 0);
    add(4, 2, 0, 7, 0, 0, 0, 7, 1, 0);
    add(1, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    // s3: release glitch 0,0,1 then clean release
    add(3, 3, 0, 4, 1, 0, 0, 0, 0, 0);
    add(1, 3, 0, 4, 1, 0, 0, 4, 1, 0);
    add(2, 3, 0, 4, 0, 0, 0, 4, 1, 0);
    add(1, 3, 0, 4, 1, 0, 0, 4, 1, 0);
    add(6, 3, 0, 4, 0, 0, 0, 4, 1, 0);
    add(1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    // s4: candidate change restarts qualification; 13 is pushed as-is; held changes ignored
    add(2, 4, 0, 8, 1, 0, 0, 0, 0, 0);
    add(3, 4, 0, 13, 1, 0, 0, 0, 0, 0);
    add(1, 4, 0, 13, 1, 0, 0, 13, 1, 0);
    add(2, 4, 0, 1, 1, 0, 0, 13, 1, 0);
    add(4, 4, 0, 1, 0, 0, 0, 13, 1, 0);
    add(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    // s5: six presses, no pops; 6th overrun coincides with CLR_OVR
    for (int k = 0; k < 6; k++) begin
      c_b = (k < 4) ? k : 4;
      c_a = (k + 1 < 4) ? k + 1 : 4;
      d_b = (k == 0) ? 0 : 1;
      o_b = (k >= 5);
      o_a = (k >= 4);
      add(3, 5, 0, codes[k], 1, 0, 0, 4'(d_b), 3'(c_b), o_b);
      add(1, 5, 0, codes[k], 1, 0, (k == 5), 4'd1, 3'(c_a), o_a);
      add(4, 5, 0, codes[k], 0, 0, 0, 4'd1, 3'(c_a), o_a);
    end
    add(1, 5, 0, 0, 0, 0, 1, 1, 4, 0);
    // s6: full queue, new code qualifies on a pop cycle; then drain
    add(3, 6, 0, 10, 1, 0, 0, 1, 4, 0);
    add(1, 6, 0, 10, 1, 1, 0, 2, 4, 0);
    add(4, 6, 0, 10, 0, 0, 0, 2, 4, 0);
    add(1, 6, 0, 0, 0, 1, 0, 3, 3, 0);
    add(1, 6, 0, 0, 0, 1, 0, 6, 2, 0);
    add(1, 6, 0, 0, 0, 1, 0, 10, 1, 0);
    add(1, 6, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 6, 0, 0, 0, 1, 0, 0, 0, 0);
    // s7: reset with key held, then reset mid-qualification
    add(3, 7, 0, 3, 1, 0, 0, 0, 0, 0);
    add(2, 7, 0, 3, 1, 0, 0, 3, 1, 0);
    add(1, 7, 1, 3, 1, 0, 0, 0, 0, 0);
    add(3, 7, 0, 3, 1, 0, 0, 0, 0, 0);
    add(1, 7, 0, 3, 1, 0, 0, 3, 1, 0);
    add(4, 7, 0, 3, 0, 0, 0, 3, 1, 0);
    add(1, 7, 0, 0, 0, 1, 0, 0, 0, 0);
    add(2, 7, 0, 11, 1, 0, 0, 0, 0, 0);
    add(1, 7, 1, 11, 1, 0, 0, 0, 0, 0);
    add(3, 7, 0, 11, 1, 0, 0, 0, 0, 0);
    add(1, 7, 0, 11, 1, 0, 0, 11, 1, 0);
    add(4, 7, 0, 11, 0, 0, 0, 11, 1, 0);
    add(1, 7, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].data, vecs[i].press, vecs[i].rd, vecs[i].clr);
      check(vecs[i].sid, i, vecs[i].e_dout, vecs[i].e_count, vecs[i].e_ovr);
    end

    // s8: hold DATA=2 for 50 cycles; repeats at edges 24 and 44 only with the macro
    for (int e = 1; e <= 50; e++) begin
      cycle(0, 4'd2, 1, 0, 0);
      e_cnt = (e >= 4) ? 1 : 0;
`ifdef KEYBUF_AUTOREPEAT_EN
      e_cnt += (e >= 24) ? 1 : 0;
      e_cnt += (e >= 44) ? 1 : 0;
`endif
      check(8, e, (e_cnt != 0) ? 4'd2 : 4'd0, 3'(e_cnt), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
